// File: rtl/seq_multiplier8_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_multiplier8_pkg;

    // Default operand width; the product is twice as wide.
    localparam int DEFAULT_WIDTH = 8;

    // FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Product width for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Default product width.
    localparam int DEFAULT_PROD_W = prod_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_multiplier8_rca_adder.sv
// WIDTH-bit ripple-carry adder built from full-adder cells; purely combinational.
module rca_adder
    import seq_multiplier8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            // One full-adder cell; carry ripples to the next bit.
            assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule

// File: rtl/seq_multiplier8.sv
// Multi-cycle unsigned shift-and-add multiplier with start/busy/done handshake.
// One adder pass per CALC cycle; the carry-out is shifted into the high half.
module seq_multiplier8
    import seq_multiplier8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          busy,
    output logic                          done,
    output logic [prod_width(WIDTH)-1:0]  product
);

    localparam int PROD_W = prod_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   w_m_nxt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   w_acc_hi_nxt;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   w_acc_lo_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PROD_W-1:0]  r_product;
    logic [PROD_W-1:0]  w_product_nxt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [PROD_W-1:0]  w_shifted;

    // Add the multiplicand only when the current multiplier bit is set.
    assign w_addend = r_acc_lo[0] ? r_m : {WIDTH{1'b0}};

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (r_acc_hi),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Right shift of the running product, keeping the adder carry-out as new MSB.
    assign w_shifted = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

    // Next-state and next-datapath logic; every register holds by default.
    always_comb begin
        w_state_nxt   = r_state;
        w_m_nxt       = r_m;
        w_acc_hi_nxt  = r_acc_hi;
        w_acc_lo_nxt  = r_acc_lo;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_m_nxt      = a;
                    w_acc_hi_nxt = {WIDTH{1'b0}};
                    w_acc_lo_nxt = b;
                    w_cnt_nxt    = {CNT_W{1'b0}};
                    w_state_nxt  = ST_CALC;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_acc_hi_nxt = w_shifted[PROD_W-1:WIDTH];
                w_acc_lo_nxt = w_shifted[WIDTH-1:0];
                w_cnt_nxt    = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_product_nxt = w_shifted;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_state_nxt   = ST_CALC;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_m       <= {WIDTH{1'b0}};
            r_acc_hi  <= {WIDTH{1'b0}};
            r_acc_lo  <= {WIDTH{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_product <= {PROD_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m       <= w_m_nxt;
            r_acc_hi  <= w_acc_hi_nxt;
            r_acc_lo  <= w_acc_lo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_busy    <= (w_state_nxt == ST_CALC);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier8.sv
// Self-checking bench for seq_multiplier8: table-driven products plus
// hand-written sequences for ignored start, mid-op reset and back-to-back ops.
module tb_seq_multiplier8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks;
    int n_pass;

    seq_multiplier8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one op from IDLE (caller at a negedge) and observe 14 cycles.
    task automatic measure(input logic [7:0] ia, input logic [7:0] ib,
                           output int busy_cycles, output int done_cyc,
                           output int done_pulses, output logic [15:0] prod);
        busy_cycles = 0;
        done_cyc    = -1;
        done_pulses = 0;
        prod        = 16'hxxxx;
        start = 1'b1; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    prod     = product;
                end
            end
            @(negedge clk);
        end
    endtask

    int          bc, dc, dp, cnt;
    logic [15:0] pr;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd200, 8'd0,   16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'd255, 8'd1,   16'd255};
        vecs[6] = '{8'd128, 8'd2,   16'd256};
        vecs[7] = '{8'd170, 8'd85,  16'd14450};

        // Reset held with start asserted: reset wins, start dropped.
        rst_n = 1'b0; start = 1'b1; a = 8'd9; b = 8'd9;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_product", {16'd0, product}, 32'd0);
        rst_n = 1'b1; start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        check("start_dropped_in_reset", cnt, 32'd0);

        // Table-driven products with latency checks.
        for (int i = 0; i < 8; i++) begin
            measure(vecs[i].va, vecs[i].vb, bc, dc, dp, pr);
            check($sformatf("prod_%0d", i), {16'd0, pr}, {16'd0, vecs[i].exp});
            check($sformatf("busy_cycles_%0d", i), bc, 32'd8);
            check($sformatf("done_cycle_%0d", i), dc, 32'd9);
            check($sformatf("done_pulses_%0d", i), dp, 32'd1);
            check($sformatf("hold_%0d", i), {16'd0, product}, {16'd0, vecs[i].exp});
        end

        // Start during CALC is ignored.
        start = 1'b1; a = 8'd7; b = 8'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd0;
        cnt = 4;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("ignored_start_done_cycle", cnt, 32'd9);
        check("ignored_start_product", {16'd0, product}, 32'd42);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("ignored_start_not_queued", cnt, 32'd0);

        // Reset in the middle of CALC discards the op.
        start = 1'b1; a = 8'd100; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreset_busy_before", {31'd0, busy}, 32'd1);
        check("midreset_hold_before", {16'd0, product}, 32'd42);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_product", {16'd0, product}, 32'd0);
        rst_n = 1'b1;
        dp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dp++;
        end
        check("midreset_no_resume", dp, 32'd0);
        measure(8'd5, 8'd5, bc, dc, dp, pr);
        check("after_reset_prod", {16'd0, pr}, 32'd25);
        check("after_reset_done_cycle", dc, 32'd9);

        // Back-to-back: restart on the first IDLE cycle after done.
        start = 1'b1; a = 8'd12; b = 8'd12;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_first_done_cycle", cnt, 32'd9);
        check("b2b_first_prod", {16'd0, product}, 32'd144);
        @(negedge clk);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; a = 8'd3; b = 8'd4;
        @(negedge clk);
        start = 1'b0; a = 8'd250; b = 8'd250;
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        check("b2b_hold_during", {16'd0, product}, 32'd144);
        cnt = 1;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_second_done_cycle", cnt, 32'd9);
        check("b2b_second_prod", {16'd0, product}, 32'd12);
        @(negedge clk);
        check("b2b_done_one_cycle", {31'd0, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
